// File: rtl/radix2_divider.sv
// Multi-cycle restoring radix-2 divider for DIV/DIVU.
// Valid/ready semantics: a request transfers on a rising edge where
// divide_valid && divide_ready; a result transfers on a rising edge where
// divide_result_valid && result_ready. flush cancels both sides that cycle.
module radix2_divider #(
    parameter int CPU_DATA_WIDTH = 32
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      divide_valid,
    output logic                      divide_ready,
    input  logic                      divide_signed,
    input  logic [CPU_DATA_WIDTH-1:0] dividend,
    input  logic [CPU_DATA_WIDTH-1:0] divisor,
    input  logic                      flush,
    output logic                      divide_result_valid,
    input  logic                      result_ready,
    output logic [CPU_DATA_WIDTH-1:0] divide_result,
    output logic [CPU_DATA_WIDTH-1:0] divide_remain,
    output logic                      busy,
    output logic [1:0]                dbg_state
);

    localparam int W     = CPU_DATA_WIDTH;
    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        WAITING_STATE = 2'd0,
        LOAD_STATE    = 2'd1,
        DIVIDE_STATE  = 2'd2,
        RETURN_STATE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_count;
    logic [2*W:0]       r_partial;       // {remainder (W+1), quotient (W)}
    logic [W-1:0]       r_abs_dividend;
    logic [W-1:0]       r_abs_divisor;
    logic [W-1:0]       r_orig_dividend;
    logic               r_quot_neg;
    logic               r_rem_neg;
    logic               r_div_zero;
    logic [W-1:0]       r_result;
    logic [W-1:0]       r_remain;
    logic               r_valid;

    logic               w_dividend_neg;
    logic               w_divisor_neg;
    logic [W-1:0]       w_abs_dividend;
    logic [W-1:0]       w_abs_divisor;
    logic [2*W:0]       w_shifted;
    logic [W:0]         w_upper;
    logic [W:0]         w_diff;
    logic               w_fits;
    logic [2*W:0]       w_next_partial;
    logic [W-1:0]       w_quot;
    logic [W-1:0]       w_rem;
    logic [W-1:0]       w_final_quot;
    logic [W-1:0]       w_final_rem;

    // Operand magnitudes, taken from the live inputs on the accept edge.
    assign w_dividend_neg = divide_signed & dividend[W-1];
    assign w_divisor_neg  = divide_signed & divisor[W-1];
    assign w_abs_dividend = w_dividend_neg ? -dividend : dividend;
    assign w_abs_divisor  = w_divisor_neg  ? -divisor  : divisor;

    // One restoring step: shift, trial-subtract on the upper W+1 bits.
    assign w_shifted      = r_partial << 1;
    assign w_upper        = w_shifted[2*W:W];
    assign w_fits         = (w_upper >= {1'b0, r_abs_divisor});
    assign w_diff         = w_upper - {1'b0, r_abs_divisor};
    assign w_next_partial = w_fits ? {w_diff, w_shifted[W-1:1], 1'b1} : w_shifted;

    // Sign fix-up and divide-by-zero override for the result registers.
    // 0x80000000 / -1 needs no special case: negating 0x80000000 wraps to itself.
    assign w_quot       = r_partial[W-1:0];
    assign w_rem        = r_partial[2*W-1:W];
    assign w_final_quot = r_div_zero ? {W{1'b1}} : (r_quot_neg ? -w_quot : w_quot);
    assign w_final_rem  = r_div_zero ? r_orig_dividend : (r_rem_neg ? -w_rem : w_rem);

    assign divide_ready        = (r_state == WAITING_STATE) && !flush;
    assign busy                = (r_state != WAITING_STATE);
    assign divide_result_valid = r_valid;
    assign divide_result       = r_result;
    assign divide_remain       = r_remain;
    assign dbg_state           = r_state;

    // Control FSM and datapath registers; flush wins over every other input.
    // Results are registered on the first RETURN cycle so the sign negation
    // does not share a cycle with the last trial subtraction.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= WAITING_STATE;
            r_count         <= '0;
            r_partial       <= '0;
            r_abs_dividend  <= '0;
            r_abs_divisor   <= '0;
            r_orig_dividend <= '0;
            r_quot_neg      <= 1'b0;
            r_rem_neg       <= 1'b0;
            r_div_zero      <= 1'b0;
            r_result        <= '0;
            r_remain        <= '0;
            r_valid         <= 1'b0;
        end else if (flush) begin
            r_state <= WAITING_STATE;
            r_count <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                WAITING_STATE: begin
                    if (divide_valid) begin
                        r_abs_dividend  <= w_abs_dividend;
                        r_abs_divisor   <= w_abs_divisor;
                        r_orig_dividend <= dividend;
                        r_quot_neg      <= w_dividend_neg ^ w_divisor_neg;
                        r_rem_neg       <= w_dividend_neg;
                        r_div_zero      <= (divisor == '0);
                        r_state         <= LOAD_STATE;
                    end
                end
                LOAD_STATE: begin
                    r_partial <= {{(W+1){1'b0}}, r_abs_dividend};
                    r_count   <= '0;
                    r_state   <= DIVIDE_STATE;
                end
                DIVIDE_STATE: begin
                    r_partial <= w_next_partial;
                    r_count   <= r_count + CNT_ONE;
                    if (r_count == LAST_ITER) begin
                        r_state <= RETURN_STATE;
                    end
                end
                RETURN_STATE: begin
                    if (!r_valid) begin
                        r_result <= w_final_quot;
                        r_remain <= w_final_rem;
                        r_valid  <= 1'b1;
                    end else if (result_ready) begin
                        r_valid <= 1'b0;
                        r_state <= WAITING_STATE;
                    end
                end
                default: begin
                    r_state <= WAITING_STATE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_radix2_divider.sv
// Bench for radix2_divider: transaction-level model plus directed vectors.
module tb_radix2_divider;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset_n = 1'b1;
    logic         divide_valid = 1'b0;
    logic         divide_ready;
    logic         divide_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         flush = 1'b0;
    logic         divide_result_valid;
    logic         result_ready = 1'b1;
    logic [W-1:0] divide_result;
    logic [W-1:0] divide_remain;
    logic         busy;
    logic [1:0]   dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    radix2_divider #(.CPU_DATA_WIDTH(W)) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .divide_valid        (divide_valid),
        .divide_ready        (divide_ready),
        .divide_signed       (divide_signed),
        .dividend            (dividend),
        .divisor             (divisor),
        .flush               (flush),
        .divide_result_valid (divide_result_valid),
        .result_ready        (result_ready),
        .divide_result       (divide_result),
        .divide_remain       (divide_remain),
        .busy                (busy),
        .dbg_state           (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Architectural DIV/DIVU result, straight from arithmetic.
    function automatic void ref_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = '0;
            end else begin
                q = W'($signed(a) / $signed(b));
                r = W'($signed(a) % $signed(b));
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // ---------------- transaction model / scoreboard ----------------
    // Phases: 0 idle, 1 computing (fixed latency), 2 result presented.
    logic [2*W-1:0] exp_q[$];
    int           m_phase = 0;
    int           m_cnt = 0;
    logic         m_valid = 1'b0;
    logic [W-1:0] m_res = '0;
    logic [W-1:0] m_rem = '0;

    always @(posedge clock or negedge reset_n) begin
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic [2*W-1:0] e;
        if (!reset_n) begin
            m_phase = 0;
            m_cnt   = 0;
            m_valid = 1'b0;
            m_res   = '0;
            m_rem   = '0;
            exp_q.delete();
        end else if (flush) begin
            m_phase = 0;
            m_valid = 1'b0;
            exp_q.delete();
        end else begin
            case (m_phase)
                0: if (divide_valid) begin
                    ref_div(divide_signed, dividend, divisor, q, r);
                    exp_q.push_back({q, r});
                    m_cnt   = 0;
                    m_phase = 1;
                end
                1: begin
                    m_cnt++;
                    if (m_cnt == W + 2) begin
                        e       = exp_q.pop_front();
                        m_res   = e[2*W-1:W];
                        m_rem   = e[W-1:0];
                        m_valid = 1'b1;
                        m_phase = 2;
                    end
                end
                2: if (result_ready) begin
                    m_valid = 1'b0;
                    m_phase = 0;
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clock) begin
        if (chk_en && reset_n) begin
            check("cyc valid",  W'(divide_result_valid), W'(m_valid));
            check("cyc ready",  W'(divide_ready), W'((m_phase == 0) && !flush));
            check("cyc busy",   W'(busy), W'(m_phase != 0));
            check("cyc result", divide_result, m_res);
            check("cyc remain", divide_remain, m_rem);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clock); #1;
        divide_valid  = 1'b1;
        divide_signed = sgn;
        dividend      = a;
        divisor       = b;
        @(posedge clock); #1;          // accept edge has just passed
        divide_valid  = 1'b0;
        dividend      = 32'hDEAD_BEEF; // operands must not be re-sampled
        divisor       = 32'h0000_0003;
        divide_signed = ~sgn;
    endtask

    task automatic run_div(input string name, input logic sgn, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] eq, input logic [W-1:0] er);
        int lat;
        bit seen;
        issue(sgn, a, b);
        lat  = 0;
        seen = 0;
        while (!seen && lat < 100) begin
            @(posedge clock); #1;
            lat++;
            if (divide_result_valid) seen = 1;
        end
        check({name, " latency"}, W'(lat), W'(34));
        check({name, " quotient"}, divide_result, eq);
        check({name, " remainder"}, divide_remain, er);
        if (result_ready) begin
            @(posedge clock); #1;
            check({name, " valid one cycle"}, W'(divide_result_valid), '0);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [W-1:0] held_q;
        logic [W-1:0] held_r;

        #3 reset_n = 1'b0;
        #20;
        check("reset result", divide_result, '0);
        check("reset remain", divide_remain, '0);
        check("reset valid",  W'(divide_result_valid), '0);
        check("reset busy",   W'(busy), '0);
        check("reset ready",  W'(divide_ready), W'(1));
        reset_n = 1'b1;
        chk_en  = 1'b1;

        run_div("divu 100/7",      1'b0, 32'd100,       32'd7,         32'd14,        32'd2);
        run_div("div -7/2",        1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("div 7/-2",        1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001);
        run_div("div ovf",         1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000);
        run_div("divu by zero",    1'b0, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 32'h1234_5678);
        run_div("div -100 by 0",   1'b1, 32'hFFFF_FF9C, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FF9C);
        run_div("div -9/-4",       1'b1, 32'hFFFF_FFF7, 32'hFFFF_FFFC, 32'd2,         32'hFFFF_FFFF);
        run_div("divu max/1",      1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0);
        run_div("divu 5/9",        1'b0, 32'd5,         32'd9,         32'd0,         32'd5);
        run_div("divu max/max",    1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         32'd0);

        // Consumer back-pressure: result held 5 cycles.
        result_ready = 1'b0;
        run_div("hold 1000/9",     1'b0, 32'd1000,      32'd9,         32'd111,       32'd1);
        held_q = divide_result;
        held_r = divide_remain;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            check("hold valid",  W'(divide_result_valid), W'(1));
            check("hold ready",  W'(divide_ready), '0);
            check("hold result", divide_result, 32'd111);
            check("hold remain", divide_remain, held_r);
            check("hold quot stable", divide_result, held_q);
        end
        result_ready = 1'b1;
        @(posedge clock); #1;
        check("release busy",   W'(busy), '0);
        check("release valid",  W'(divide_result_valid), '0);
        check("release result", divide_result, 32'd111);

        // Flush 10 cycles after accept.
        issue(1'b0, 32'd1000, 32'd3);
        repeat (9) @(posedge clock);
        #1 flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        check("flush busy",  W'(busy), '0);
        check("flush valid", W'(divide_result_valid), '0);
        run_div("divu 9/3 after flush", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

        // Flush coincident with a request: not accepted.
        @(posedge clock); #1;
        divide_valid  = 1'b1;
        flush         = 1'b1;
        divide_signed = 1'b0;
        dividend      = 32'd5;
        divisor       = 32'd1;
        @(posedge clock); #1;
        divide_valid = 1'b0;
        flush        = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("flush+valid not accepted", W'(busy), '0);
            @(posedge clock); #1;
        end

        // Asynchronous reset in the middle of DIVIDE.
        issue(1'b0, 32'd50000, 32'd7);
        repeat (10) @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        check("midreset result", divide_result, '0);
        check("midreset remain", divide_remain, '0);
        check("midreset valid",  W'(divide_result_valid), '0);
        check("midreset busy",   W'(busy), '0);
        #1 reset_n = 1'b1;
        run_div("divu after reset", 1'b0, 32'd50000, 32'd7, 32'd7142, 32'd6);

        repeat (3) @(posedge clock);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/radix2_divider.md
Name: radix2_divider

Overview:
- Multi-cycle restoring radix-2 divider serving DIV/DIVU for the EX stage.
- EX is the initiator: it raises divide_valid together with its operands.
- This block is the responder. It returns quotient and remainder with divide_result_valid, which EX forwards to the IO stage for the HI/LO write.
- The control FSM uses the divider State encoding: WAITING_STATE, LOAD_STATE, DIVIDE_STATE, RETURN_STATE.

Parameters:
- CPU_DATA_WIDTH, 32, operand/result width; iteration count equals this value.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- divide_valid  in  1  EX presents a divide request.
- divide_ready  out  1  divider can accept a request this cycle.
- divide_signed  in  1  1 = DIV (two's complement), 0 = DIVU.
- dividend  in  CPU_DATA_WIDTH  rs value.
- divisor  in  CPU_DATA_WIDTH  rt value.
- flush  in  1  WB exception/eret flush; cancels any operation.
- divide_result_valid  out  1  quotient/remainder valid.
- result_ready  in  1  consumer takes the result this cycle.
- divide_result  out  CPU_DATA_WIDTH  quotient (LO).
- divide_remain  out  CPU_DATA_WIDTH  remainder (HI).
- busy  out  1  state != WAITING_STATE.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=WAITING_STATE, iteration counter=0.
  - divide_result=0, divide_remain=0, divide_result_valid=0, busy=0.
- divide_ready = (state==WAITING_STATE) && !flush.
  - A request is accepted on a rising edge where divide_valid && divide_ready.
  - Operands are sampled only on that edge.
- WAITING -> LOAD on accept. Latched at accept:
  - |dividend| and |divisor| (two's-complement negate if divide_signed and MSB=1).
  - quotient sign = sign(dividend) XOR sign(divisor), signed only.
  - remainder sign = sign(dividend), signed only.
  - divisor_zero flag.
  - original dividend.
- LOAD (1 cycle):
  - partial register {CPU_DATA_WIDTH+1 zeros, |dividend|}.
  - counter=0.
  - -> DIVIDE.
- DIVIDE (exactly CPU_DATA_WIDTH cycles), each cycle:
  - Shift partial left 1.
  - Trial-subtract |divisor| from the upper CPU_DATA_WIDTH+1 bits.
  - If non-negative: upper bits take the difference and quotient LSB=1; else quotient LSB=0.
  - counter++; when counter==CPU_DATA_WIDTH-1 -> RETURN.
- Entering RETURN, the output registers are loaded with:
  - quotient, negated if quotient sign=1.
  - remainder, negated if remainder sign=1.
  - divide_result_valid=1.
- Latency: accept on edge 0 -> divide_result_valid high from edge CPU_DATA_WIDTH+2 (34 for default). Fixed, independent of operand values.
- RETURN:
  - Outputs held stable while result_ready=0.
  - On result_ready=1: -> WAITING; divide_result_valid drops next cycle; outputs keep their last value.
  - No new request is accepted in the same cycle as the release (divide_ready is low in RETURN).
- Divisor zero: result forced to divide_result=all ones, divide_remain=original dividend, for both signed and unsigned. Same latency.
- Signed overflow 0x80000000 / -1: divide_result=0x80000000, divide_remain=0. No exception.
- flush:
  - In any state, next state is WAITING and divide_result_valid=0 next cycle.
  - The partial result is discarded.
  - flush overrides result_ready and divide_valid in the same cycle.
- Asynchronous reset mid-operation behaves identically to power-on reset.
- All arithmetic in the DIVIDE loop is unsigned on CPU_DATA_WIDTH+1 bits; no multi-cycle paths.

Test Plan:
- DIVU 100 / 7, result_ready=1:
  - divide_result=14, divide_remain=2.
  - divide_result_valid exactly 34 cycles after accept, high 1 cycle.
- DIV -7 / 2: divide_result=0xFFFFFFFD, divide_remain=0xFFFFFFFF. DIV 7 / -2: 0xFFFFFFFD, 0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF: divide_result=0x80000000, divide_remain=0. DIVU 0x12345678 / 0: divide_result=0xFFFFFFFF, divide_remain=0x12345678.
- result_ready held low 5 cycles after valid:
  - outputs and divide_result_valid stable, divide_ready=0.
  - release -> busy=0 next cycle.
- flush asserted 10 cycles after accept:
  - WAITING next cycle, no divide_result_valid.
  - DIVU 9 / 3 issued immediately after returns 3, 0 with full 34-cycle latency.
  - flush coincident with divide_valid in WAITING -> request not accepted.
- reset_n pulsed low mid-DIVIDE (between clock edges):
  - outputs zero immediately, state WAITING.
  - next request completes correctly.
